muldiv_sequencer: RTL

- Iterative RV32M multiply/divide unit with its own sequencing FSM. It sits beside the ALU in the execute stage.
- It accepts one operation per request handshake and runs a shift-add multiply or a restoring divide over XLEN cycles.
- It raises busy so the pipeline holds EX, then presents the result through a valid/ready handshake.
- Div-by-zero and signed overflow are resolved without iterating.

---
 rtl/muldiv_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit with an IDLE/CALC/DONE sequencer and valid/ready result handshake.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle instead of iterating.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2:0]        op;
  logic              sign_a, sign_b, special;
  logic [XLEN-1:0]   opnd, res_q;
  logic [2*XLEN-1:0] acc;

  // Accept-time decode: operand signs, magnitudes and the no-iteration corner cases
  logic            accept, is_div, sgn_a_in, sgn_b_in, neg_a, neg_b;
  logic            div_zero, div_ovf, special_in, fast;
  logic [XLEN-1:0] abs_a_in, abs_b_in, special_val;

  assign accept   = req_valid && req_ready && !flush;
  assign is_div   = funct3[2];
  assign sgn_a_in = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign sgn_b_in = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign neg_a    = sgn_a_in && SrcA[XLEN-1];
  assign neg_b    = sgn_b_in && SrcB[XLEN-1];
  assign abs_a_in = neg_a ? -SrcA : SrcA;
  assign abs_b_in = neg_b ? -SrcB : SrcB;

  assign div_zero   = is_div && (SrcB == '0);
  assign div_ovf    = is_div && !funct3[0] && (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
  assign special_in = div_zero || div_ovf;
  // Overflow DIV returns the dividend itself; zero-divisor REM returns the dividend too
  assign special_val = div_zero ? (funct3[1] ? SrcA : '1) : (funct3[1] ? '0 : SrcA);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, abs_a_in} * {{XLEN{1'b0}}, abs_b_in};
  assign fast      = !is_div;
`else
  assign fast      = 1'b0;
`endif

  // One iteration step. Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient}
  logic [XLEN:0]     mul_sum, div_trial;
  logic [2*XLEN-1:0] mul_step, div_step;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step  = {mul_sum, acc[XLEN-1:1]};
  assign div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opnd};
  assign div_step  = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (special_in || fast) ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      special <= 1'b0;
      opnd    <= '0;
      res_q   <= '0;
      acc     <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        op      <= funct3;
        sign_a  <= neg_a;
        sign_b  <= neg_b;
        special <= special_in;
        res_q   <= special_val;
        opnd    <= is_div ? abs_b_in : abs_a_in;
        acc     <= {{XLEN{1'b0}}, (is_div ? abs_a_in : abs_b_in)};
        cnt     <= (special_in || fast) ? '0 : CW'(XLEN);
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div) acc <= fast_prod;
`endif
      end else if (state == CALC) begin
        cnt <= cnt - CW'(1);
        acc <= op[2] ? div_step : mul_step;
      end
    end
  end

  // Sign fix-up sits on the output path so DONE is reached without an extra cycle
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

  assign prod     = (sign_a ^ sign_b) ? -acc : acc;
  assign quot_fix = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    final_res = '0;
    if (special)          final_res = res_q;
    else if (!op[2])      final_res = (op == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op[1])       final_res = rem_fix;
    else                  final_res = quot_fix;
  end

  assign req_ready    = (state == IDLE);
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign result       = (state == DONE) ? final_res : '0;

endmodule
